// File: rtl/vae_pkg.sv
// Shared types and helpers for the VAE datapath lanes.
package vae_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Widest accumulator any lane hands to sat_trunc; callers sign-extend to this.
  localparam int SAT_MAX_W = 64;
  localparam logic signed [SAT_MAX_W-1:0] SAT_ONE = 64'sd1;

  // Arithmetic shift right by frac (truncates toward -inf), then clamp to a
  // signed out_w-bit range. Callers keep the low out_w bits of the result.
  function automatic logic signed [SAT_MAX_W-1:0] sat_trunc(
    input logic signed [SAT_MAX_W-1:0] v,
    input int                          out_w,
    input int                          frac
  );
    logic signed [SAT_MAX_W-1:0] sh, hi, lo, r;
    sh = v >>> frac;
    hi = (SAT_ONE <<< (out_w - 1)) - SAT_ONE;
    lo = -(SAT_ONE <<< (out_w - 1));
    if (sh > hi)      r = hi;
    else if (sh < lo) r = lo;
    else              r = sh;
    return r;
  endfunction

endpackage

// File: rtl/register.sv
// Plain synchronous register with clear. The enable input is not used; owners
// gate loads by feeding q back into d.
module register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic unused_en;
  assign unused_en = en;

  // Reset or clear wins, otherwise load d every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) q <= '0;
    else               q <= d;
  end

endmodule

// File: rtl/dot_seq_ctrl.sv
// Dot-product lane sequencer: takes a start/len command, streams operand
// pairs through a product register into a wide accumulator, and returns one
// saturated Q-format result over a valid/ready handshake.
module dot_seq_ctrl
  import vae_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int ACC_W   = 2 * WIDTH + LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
);

  localparam int PROD_W = 2 * WIDTH;

  state_e                      state_q;
  logic [LEN_W-1:0]            len_q, count_q, len_eff;
  logic                        prod_vld_q, busy_q, out_valid_q;
  logic                        beat, start_acc;
  logic signed [PROD_W-1:0]    mul;
  logic [PROD_W-1:0]           prod_d, prod_q;
  logic [ACC_W-1:0]            acc_d, acc_q;
  logic [WIDTH-1:0]            res_d, res_q;
  logic signed [SAT_MAX_W-1:0] acc_ext, sat_full;
  logic [SAT_MAX_W-WIDTH-1:0]  unused_sat_hi;

  assign len_eff   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign in_ready  = (state_q == ACCUM) && (count_q < len_q);
  assign beat      = in_valid && in_ready;
  assign start_acc = (state_q == IDLE) && start;

  // Datapath next-state: product loads on a beat, accumulator adds the
  // pending product, result captures on the DRAIN cycle. The result uses
  // acc_d so the last product is included in the same edge.
  assign mul     = PROD_W'(a) * PROD_W'(b);
  assign prod_d  = beat ? mul : prod_q;
  assign acc_d   = prod_vld_q ? acc_q + {{LEN_W{prod_q[PROD_W-1]}}, prod_q} : acc_q;
  assign acc_ext = {{(SAT_MAX_W-ACC_W){acc_d[ACC_W-1]}}, acc_d};
  assign sat_full      = sat_trunc(acc_ext, WIDTH, FRAC);
  assign unused_sat_hi = sat_full[SAT_MAX_W-1:WIDTH];
  assign res_d   = (state_q == DRAIN) ? sat_full[WIDTH-1:0] : res_q;

  register #(.W(PROD_W)) u_prod (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(start_acc), .d(prod_d), .q(prod_q)
  );

  register #(.W(ACC_W)) u_acc (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(start_acc), .d(acc_d), .q(acc_q)
  );

  register #(.W(WIDTH)) u_res (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .d(res_d), .q(res_q)
  );

  // Control FSM with beat counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      prod_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= len_eff;
            count_q    <= '0;
            prod_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (len_eff == '0) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          prod_vld_q <= beat;
          if (beat) begin
            count_q <= count_q + 1'b1;
            if (count_q + 1'b1 == len_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          prod_vld_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;

endmodule

// File: doc/dot_seq_ctrl.md
# dot_seq_ctrl

Sequencer for one fixed-point dot-product lane of the VAE datapath. It accepts a start command with a vector length, streams operand pairs through a valid/ready handshake, and drives a registered product stage and an accumulator register, using `register` instances with `en`/`clr` control. It returns one saturated Q-format result through an output valid/ready handshake. Encoder and decoder layer controllers instantiate one per output neuron lane.

## Interface
- `WIDTH`, 16: signed operand and result width.
- `FRAC`, 8: fractional bits of operands and result (Q(WIDTH-FRAC).FRAC).
- `MAX_LEN`, 256: maximum vector length.
- `LEN_W`, $clog2(MAX_LEN+1): width of `len` and the beat counter.
- `ACC_W`, 2*WIDTH+LEN_W: accumulator width; it never overflows.

- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: command strobe. Sampled only in IDLE.
- `len` in LEN_W: vector length, latched on an accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: lane can accept a pair.
- `a`, `b` in WIDTH, signed: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out WIDTH, signed: saturated result.

## Operation
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - `start`=1 latches `len`, clears the accumulator and the product-valid flag, and moves to ACCUM.
  - If `len`=0, it moves to DRAIN instead.
- ACCUM:
  - `in_ready` = (count < len_q).
  - A beat is accepted when `in_valid`&&`in_ready`. The product register loads a*b (2*WIDTH signed), prod_vld is set, and count increments.
  - While prod_vld=1, the accumulator adds the sign-extended product each cycle. prod_vld clears on any cycle with no accepted beat.
  - When the final beat is accepted (count reaches len_q−1), the next state is DRAIN.
- DRAIN:
  - One cycle. The last product is added.
  - The result register loads sat(acc >>> FRAC). The shift is arithmetic, so rounding truncates toward −∞.
  - The next state is OUT.
- Saturation: values > 2^(WIDTH−1)−1 clamp to 0x7FFF; values < −2^(WIDTH−1) clamp to 0x8000 (WIDTH=16).
- OUT:
  - `out_valid`=1 and `out_data` is held stable until `out_ready`=1.
  - On that handshake edge the next state is IDLE.
- `start` while busy is ignored, with no queueing.
- `in_valid` outside ACCUM is ignored.
- `in_ready` is 0 in every state except ACCUM.
- `len` > MAX_LEN is clamped to MAX_LEN.

## Timing
- Reset (any state, mid-vector included):
  - Next edge: state=IDLE, count=0, acc=0, product=0, prod_vld=0.
  - Outputs: `out_data`=0, `out_valid`=0, `in_ready`=0, `busy`=0.
  - A partial vector is discarded.
- `busy` rises on the edge after the accepted `start`.
- `in_ready` can be 1 in the first cycle after `start`.
- Full throughput: one beat per cycle while `in_valid` is held high.
- Gaps in `in_valid` are allowed at any point.
- Latency: `out_valid` rises 2 edges after the edge that accepts the final beat (product edge, then DRAIN edge).
- `len`=0: `out_valid` with `out_data`=0 two edges after `start`.
- Back-to-back: a `start` can be accepted on the first IDLE cycle after the OUT handshake, i.e. one idle cycle minimum between results.
- `out_ready` high before `out_valid`: the handshake completes in the first OUT cycle.

## Structure
- Shared package `vae_pkg`:
  - state enum encoding (IDLE=0, ACCUM=1, DRAIN=2, OUT=3);
  - a saturating-truncate function parameterised on input/output widths and FRAC, reused by other lanes.
- Sub-module: the existing `register` for the product stage, accumulator and result.
  - Its `clr` clears acc on start.
  - Load gating is done in this block by muxing `d` to `q`, because `register` ignores `en`.
- One FSM plus one LEN_W counter. Target ~200 lines.

## Test plan
- len=3, pairs (0x0100,0x0100)×3, `out_ready`=1 → `out_data`=0x0300, `out_valid` 2 edges after the third beat.
- len=1, a=0xFF00 (−1.0), b=0x0200 (2.0) → `out_data`=0xFE00.
- len=4, a=b=0x7FFF → `out_data`=0x7FFF; len=4, a=0x8000, b=0x7FFF → `out_data`=0x8000.
- len=4 with `in_valid` toggling 1,0,0,1,1,0,1, then `out_ready` low 5 cycles with `start` pulsed during OUT → `out_data`=0x0400 for a=b=0x0100; data stable while stalled; `start` ignored; one result only.
- len=0 → `out_data`=0x0000, `out_valid` 2 edges after `start`, `in_ready` never 1.
- `rst_n` low for 1 cycle after 2 of 5 beats, then a new start with len=2 and a=b=0x0080 → all outputs 0 after reset; new result 0x0080 (0.25+0.25) with no residue.
